// File: rtl/axi_stream_mux_2to1.sv
// Two-input to one-output AXI-Stream mux with a registered output stage and a one-entry skid buffer.
// Optional per-stream accepted-beat counters are enabled by defining XFER_CNT_EN.
module axi_stream_mux_2to1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] tdata_0,
  input  logic                  tvalid_0,
  output logic                  tready_0,
  input  logic [DATA_WIDTH-1:0] tdata_1,
  input  logic                  tvalid_1,
  output logic                  tready_1,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic                  tvalid_out,
  input  logic                  tready_out
`ifdef XFER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt_0,
  output logic [15:0]           xfer_cnt_1
`endif
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high; valid never
  // depends on ready, and the output holds data/valid stable while tvalid_out & !tready_out.

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_full_q, skid_full_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_advance;

  // Only the selected input ever sees ready; a full skid stalls both.
  assign tready_0 = !rst && !skid_full_q && !sel;
  assign tready_1 = !rst && !skid_full_q && sel;

  assign accept      = sel ? (tvalid_1 && tready_1) : (tvalid_0 && tready_0);
  assign in_data     = sel ? tdata_1 : tdata_0;
  assign out_advance = !out_valid_q || tready_out;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    if (out_advance) begin
      // The skid beat is older than anything arriving now, so it goes first.
      if (skid_full_q) begin
        out_data_d  = skid_data_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d = in_data;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign tdata_out  = out_data_q;
  assign tvalid_out = out_valid_q;

`ifdef XFER_CNT_EN
  logic [15:0] cnt_0_q, cnt_0_d;
  logic [15:0] cnt_1_q, cnt_1_d;

  always_comb begin
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (accept && !sel) cnt_0_d = cnt_0_q + 16'd1;
    if (accept && sel)  cnt_1_d = cnt_1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign xfer_cnt_0 = cnt_0_q;
  assign xfer_cnt_1 = cnt_1_q;
`endif

endmodule

// File: tb/tb_axi_stream_mux_2to1.sv
// Directed testbench for axi_stream_mux_2to1; counter scenarios run when XFER_CNT_EN is defined.
module tb_axi_stream_mux_2to1;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         sel;
  logic [W-1:0] tdata_0;
  logic         tvalid_0;
  logic         tready_0;
  logic [W-1:0] tdata_1;
  logic         tvalid_1;
  logic         tready_1;
  logic [W-1:0] tdata_out;
  logic         tvalid_out;
  logic         tready_out;
`ifdef XFER_CNT_EN
  logic [15:0]  xfer_cnt_0;
  logic [15:0]  xfer_cnt_1;
`endif

  int checks;
  int errors;

  axi_stream_mux_2to1 #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .tdata_0    (tdata_0),
    .tvalid_0   (tvalid_0),
    .tready_0   (tready_0),
    .tdata_1    (tdata_1),
    .tvalid_1   (tvalid_1),
    .tready_1   (tready_1),
    .tdata_out  (tdata_out),
    .tvalid_out (tvalid_out),
    .tready_out (tready_out)
`ifdef XFER_CNT_EN
    ,
    .xfer_cnt_0 (xfer_cnt_0),
    .xfer_cnt_1 (xfer_cnt_1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0;
    tdata_0 = 32'hAA; tvalid_0 = 1'b1;
    tdata_1 = 32'hBB; tvalid_1 = 1'b1;
    tready_out = 1'b1;
    step(); step();
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL reset_tvalid_out got %h exp 0", tvalid_out); end
    checks++; if (tdata_out !== 32'h0) begin errors++; $display("FAIL reset_tdata_out got %h exp 0", tdata_out); end
    checks++; if (tready_0 !== 1'b0) begin errors++; $display("FAIL reset_tready_0 got %h exp 0", tready_0); end
    checks++; if (tready_1 !== 1'b0) begin errors++; $display("FAIL reset_tready_1 got %h exp 0", tready_1); end
    tvalid_0 = 1'b0; tvalid_1 = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (tready_0 !== 1'b1) begin errors++; $display("FAIL post_reset_tready_0 got %h exp 1", tready_0); end
    checks++; if (tready_1 !== 1'b0) begin errors++; $display("FAIL post_reset_tready_1 got %h exp 0", tready_1); end
  endtask

  task automatic test_select_1();
    sel = 1'b1;
    tdata_1 = 32'h96; tvalid_1 = 1'b1;
    tdata_0 = 32'h78; tvalid_0 = 1'b1;
    tready_out = 1'b1;
    #1;
    checks++; if (tready_0 !== 1'b0) begin errors++; $display("FAIL sel1_tready_0 got %h exp 0", tready_0); end
    checks++; if (tready_1 !== 1'b1) begin errors++; $display("FAIL sel1_tready_1 got %h exp 1", tready_1); end
    step();
    tvalid_1 = 1'b0;
    checks++; if (tdata_out !== 32'h96) begin errors++; $display("FAIL sel1_tdata_out got %h exp 96", tdata_out); end
    checks++; if (tvalid_out !== 1'b1) begin errors++; $display("FAIL sel1_tvalid_out got %h exp 1", tvalid_out); end
    step();
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL sel1_drain_tvalid got %h exp 0", tvalid_out); end
    checks++; if (tdata_out !== 32'h96) begin errors++; $display("FAIL sel1_no_78 got %h exp 96", tdata_out); end
    tvalid_0 = 1'b0;
  endtask

  task automatic test_select_0();
    sel = 1'b0;
    tdata_0 = 32'h124; tvalid_0 = 1'b1;
    tdata_1 = 32'h55;  tvalid_1 = 1'b1;
    tready_out = 1'b1;
    #1;
    checks++; if (tready_1 !== 1'b0) begin errors++; $display("FAIL sel0_tready_1 got %h exp 0", tready_1); end
    step();
    tvalid_0 = 1'b0;
    checks++; if (tdata_out !== 32'h124) begin errors++; $display("FAIL sel0_tdata_out got %h exp 124", tdata_out); end
    checks++; if (tvalid_out !== 1'b1) begin errors++; $display("FAIL sel0_tvalid_out got %h exp 1", tvalid_out); end
    step();
    tvalid_1 = 1'b0;
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL sel0_drain_tvalid got %h exp 0", tvalid_out); end
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    tready_out = 1'b0;
    tdata_1 = 32'h125; tvalid_1 = 1'b1;
    step();
    checks++; if (tdata_out !== 32'h125) begin errors++; $display("FAIL bp_first_data got %h exp 125", tdata_out); end
    checks++; if (tready_1 !== 1'b1) begin errors++; $display("FAIL bp_ready_before_skid got %h exp 1", tready_1); end
    tdata_1 = 32'h136;
    step();
    tdata_1 = 32'h999;
    checks++; if (tready_1 !== 1'b0) begin errors++; $display("FAIL bp_ready_skid_full got %h exp 0", tready_1); end
    checks++; if (tdata_out !== 32'h125) begin errors++; $display("FAIL bp_hold_data got %h exp 125", tdata_out); end
    step();
    checks++; if (tdata_out !== 32'h125 || tvalid_out !== 1'b1) begin errors++; $display("FAIL bp_stable got %h/%h exp 125/1", tdata_out, tvalid_out); end
    checks++; if (tready_1 !== 1'b0) begin errors++; $display("FAIL bp_ready_still_low got %h exp 0", tready_1); end
    tvalid_1 = 1'b0;
    tready_out = 1'b1;
    step();
    checks++; if (tdata_out !== 32'h136 || tvalid_out !== 1'b1) begin errors++; $display("FAIL bp_skid_out got %h/%h exp 136/1", tdata_out, tvalid_out); end
    checks++; if (tready_1 !== 1'b1) begin errors++; $display("FAIL bp_ready_restored got %h exp 1", tready_1); end
    step();
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL bp_drained_valid got %h exp 0", tvalid_out); end
  endtask

  task automatic test_idle();
    tvalid_0 = 1'b0; tvalid_1 = 1'b0; tready_out = 1'b0;
    step(); step();
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL idle_tvalid got %h exp 0", tvalid_out); end
    checks++; if (tdata_out !== 32'h136) begin errors++; $display("FAIL idle_tdata_hold got %h exp 136", tdata_out); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;
    sel = 1'b0;
    tready_out = 1'b1;
    tvalid_0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tdata_0 = 32'h200 + i;
      exp_q.push_back(tdata_0);
      step();
      exp = exp_q.pop_front();
      checks++; if (tdata_out !== exp || tvalid_out !== 1'b1) begin errors++; $display("FAIL b2b_beat%0d got %h/%h exp %h/1", i, tdata_out, tvalid_out, exp); end
    end
    tvalid_0 = 1'b0;
    step();
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %h exp 0", tvalid_out); end
  endtask

  task automatic test_reset_mid_op();
    sel = 1'b1; tready_out = 1'b0;
    tdata_1 = 32'h301; tvalid_1 = 1'b1;
    step();
    tdata_1 = 32'h302;
    step();
    rst = 1'b1;
    #1;
    checks++; if (tvalid_out !== 1'b0 || tdata_out !== 32'h0) begin errors++; $display("FAIL midrst_out got %h/%h exp 0/0", tdata_out, tvalid_out); end
    tvalid_1 = 1'b0;
    step();
    rst = 1'b0; tready_out = 1'b1;
    #1;
    checks++; if (tready_1 !== 1'b1) begin errors++; $display("FAIL midrst_skid_cleared got %h exp 1", tready_1); end
    step();
    checks++; if (tvalid_out !== 1'b0) begin errors++; $display("FAIL midrst_no_stale got %h exp 0", tvalid_out); end
  endtask

`ifdef XFER_CNT_EN
  task automatic test_counters();
    rst = 1'b1; step(); rst = 1'b0;
    tready_out = 1'b1;
    sel = 1'b0; tvalid_0 = 1'b1; tdata_0 = 32'h1;
    step(); step(); step();
    tvalid_0 = 1'b0;
    sel = 1'b1; tvalid_1 = 1'b1; tdata_1 = 32'h2;
    step(); step();
    tvalid_1 = 1'b0;
    step();
    checks++; if (xfer_cnt_0 !== 16'd3) begin errors++; $display("FAIL cnt0 got %0d exp 3", xfer_cnt_0); end
    checks++; if (xfer_cnt_1 !== 16'd2) begin errors++; $display("FAIL cnt1 got %0d exp 2", xfer_cnt_1); end
    sel = 1'b0; tvalid_0 = 1'b1;
    for (int i = 0; i < 65532; i++) step();
    tvalid_0 = 1'b0;
    step();
    checks++; if (xfer_cnt_0 !== 16'hFFFF) begin errors++; $display("FAIL cnt0_max got %h exp ffff", xfer_cnt_0); end
    tvalid_0 = 1'b1;
    step();
    tvalid_0 = 1'b0;
    checks++; if (xfer_cnt_0 !== 16'h0000) begin errors++; $display("FAIL cnt0_wrap got %h exp 0000", xfer_cnt_0); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; sel = 1'b0;
    tdata_0 = '0; tvalid_0 = 1'b0;
    tdata_1 = '0; tvalid_1 = 1'b0;
    tready_out = 1'b0;
    test_reset();
    test_select_1();
    test_select_0();
    test_backpressure();
    test_idle();
    test_back_to_back();
    test_reset_mid_op();
`ifdef XFER_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
